alu_exec_unit: RTL

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_unit.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// Single-issue ALU: non-shift ops finish in 1 cycle, shifts step one bit per cycle in SHIFT.
// Optional macro OVERFLOW_DETECT_EN adds the registered signed-overflow flag for ADD/SUB.
module alu_exec_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        InValid,
  output logic        InReady,
  input  logic [3:0]  ALUCtrl,
  input  logic [31:0] BusA,
  input  logic [31:0] BusB,
  input  logic [4:0]  ShAmt,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] BusW,
  output logic        Zero,
  output logic        Overflow
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_ADDU = 4'b1000;
  localparam logic [3:0] OP_SUBU = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_LUI  = 4'b1110;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] res_q, res_d;
  logic        zero_q, zero_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;

  logic [31:0] sum, diff, alu_res, shifted;
  logic        is_shift;

  assign sum      = BusA + BusB;
  assign diff     = BusA - BusB;
  assign is_shift = (ALUCtrl == OP_SLL) || (ALUCtrl == OP_SRL) || (ALUCtrl == OP_SRA);

  // Shift ops pass BusB through here; the actual shifting happens in SHIFT.
  always_comb begin
    alu_res = 32'h0;
    case (ALUCtrl)
      OP_AND:                alu_res = BusA & BusB;
      OP_OR:                 alu_res = BusA | BusB;
      OP_ADD, OP_ADDU:       alu_res = sum;
      OP_SUB, OP_SUBU:       alu_res = diff;
      OP_SLT:                alu_res = {31'b0, $signed(BusA) < $signed(BusB)};
      OP_SLTU:               alu_res = {31'b0, BusA < BusB};
      OP_XOR:                alu_res = BusA ^ BusB;
      OP_NOR:                alu_res = ~(BusA | BusB);
      OP_LUI:                alu_res = {BusB[15:0], 16'h0000};
      OP_SLL, OP_SRL, OP_SRA: alu_res = BusB;
      default:               alu_res = 32'h0;
    endcase
  end

  always_comb begin
    shifted = res_q;
    case (op_q)
      OP_SLL:  shifted = {res_q[30:0], 1'b0};
      OP_SRL:  shifted = {1'b0, res_q[31:1]};
      OP_SRA:  shifted = {res_q[31], res_q[31:1]};
      default: shifted = res_q;
    endcase
  end

`ifdef OVERFLOW_DETECT_EN
  logic ovf_q, ovf_d, alu_ovf;

  always_comb begin
    alu_ovf = 1'b0;
    if (ALUCtrl == OP_ADD)
      alu_ovf = (BusA[31] == BusB[31]) && (sum[31] != BusA[31]);
    else if (ALUCtrl == OP_SUB)
      alu_ovf = (BusA[31] != BusB[31]) && (diff[31] != BusA[31]);
  end
`endif

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    zero_d  = zero_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
`ifdef OVERFLOW_DETECT_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (InValid) begin
          op_d = ALUCtrl;
          if (is_shift && (ShAmt != 5'd0)) begin
            res_d   = BusB;
            cnt_d   = ShAmt;
            zero_d  = 1'b0;
            state_d = SHIFT;
`ifdef OVERFLOW_DETECT_EN
            ovf_d   = 1'b0;
`endif
          end else begin
            res_d   = alu_res;
            zero_d  = (alu_res == 32'h0);
            state_d = DONE;
`ifdef OVERFLOW_DETECT_EN
            ovf_d   = alu_ovf;
`endif
          end
        end
      end
      SHIFT: begin
        res_d = shifted;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          zero_d  = (shifted == 32'h0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (OutReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      res_q   <= 32'h0;
      zero_q  <= 1'b0;
      cnt_q   <= 5'd0;
      op_q    <= 4'h0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

`ifdef OVERFLOW_DETECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end
  assign Overflow = ovf_q;
`else
  assign Overflow = 1'b0;
`endif

  assign InReady  = (state_q == IDLE);
  assign OutValid = (state_q == DONE);
  assign BusW     = res_q;
  assign Zero     = zero_q;

endmodule
